// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types and constants for the seven-segment scan controller
package sseg_pkg;

   localparam int N_DIGITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam logic [6:0] HEX_FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_sseg.sv
// rtl/hex_to_sseg.sv - nibble to active-low seven-segment pattern
module hex_to_sseg
   import sseg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 8-digit multiplexed seven-segment scanner
// Slot scheduler with blanking guard, digit skipping and per-frame value latch.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int COUNTER_MAX  = 20000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  digit_en,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [2:0]  digit_idx
);

   localparam int CW = $clog2(COUNTER_MAX);
   localparam logic [CW-1:0] CNT_LAST   = CW'(COUNTER_MAX - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   scan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   val_q, val_d;
   logic [7:0]    dpl_q, dpl_d;
   logic          kill_q, kill_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    font_nibble;
   logic [6:0]    font_seg;
   logic [2:0]    nxt_idx;

   // First enabled index searched upward from cur+1, wrapping; cur itself is tried last.
   function automatic logic [2:0] next_en(input logic [7:0] en, input logic [2:0] cur);
      logic [2:0] r;
      logic [2:0] k;
      r = cur;
      for (int i = N_DIGITS; i >= 1; i--) begin
         k = cur + 3'(i);
         if (en[k]) r = k;
      end
      return r;
   endfunction

   assign nxt_idx = next_en(digit_en, idx_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      val_d   = val_q;
      dpl_d   = dpl_q;
      kill_d  = kill_q;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            idx_d  = '0;
            kill_d = 1'b0;
            if (digit_en != 8'h00) begin
               state_d = BLANK;
               idx_d   = next_en(digit_en, 3'd7);
               val_d   = value;
               dpl_d   = dp_in;
            end
         end
         BLANK: begin
            cnt_d = cnt_q + CW'(1);
            if (!digit_en[idx_q]) kill_d = 1'b1;
            if (cnt_q == BLANK_LAST) state_d = DRIVE;
         end
         DRIVE: begin
            cnt_d = cnt_q + CW'(1);
            if (!digit_en[idx_q]) kill_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d  = '0;
               kill_d = 1'b0;
               if (digit_en == 8'h00) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  state_d = BLANK;
                  idx_d   = nxt_idx;
                  // Wrapping back to a lower or equal index starts a new frame
                  if (nxt_idx <= idx_q) begin
                     val_d = value;
                     dpl_d = dp_in;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign font_nibble = val_d[{idx_d, 2'b00} +: 4];

   hex_to_sseg u_font (
      .nibble_i (font_nibble),
      .seg_o    (font_seg)
   );

   // Outputs are derived from next-state values so the registers line up with state_q
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state_d == DRIVE && !kill_d) begin
         an_d  = ~(8'h01 << idx_d);
         seg_d = font_seg;
         dp_d  = ~dpl_d[idx_d];
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         dpl_q   <= '0;
         kill_q  <= 1'b0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         dpl_q   <= dpl_d;
         kill_q  <= kill_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign digit_idx = idx_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [31:0] value;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [2:0]  digit_idx;

   int checks   = 0;
   int failures = 0;

   localparam logic [7:0] AN_TBL [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   // Fonts of 89ABCDEF nibbles 0..7: F,E,D,C,B,A,9,8
   localparam logic [6:0] SEG_TBL [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

   sseg_scan_ctrl #(
      .COUNTER_MAX  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .value     (value),
      .dp_in     (dp_in),
      .digit_en  (digit_en),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .digit_idx (digit_idx)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_off(input string tag);
      check({tag, "_an"}, 32'(an), 32'hFF);
      check({tag, "_seg"}, 32'(seg), 32'h7F);
      check({tag, "_dp"}, 32'(dp), 32'h1);
   endtask

   // One full 8-cycle slot: 2 blank cycles then 6 lit cycles
   task automatic run_slot(input logic [2:0] e_idx, input logic [7:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
      for (int c = 0; c < 8; c++) begin
         step();
         check("slot_idx", 32'(digit_idx), 32'(e_idx));
         if (c < 2) begin
            check_off("slot_blank");
         end else begin
            check("slot_an", 32'(an), 32'(e_an));
            check("slot_seg", 32'(seg), 32'(e_seg));
            check("slot_dp", 32'(dp), 32'(e_dp));
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      value    = 32'h89ABCDEF;
      dp_in    = 8'h00;
      digit_en = 8'hFF;
      step();
      step();
      check_off("reset");
      check("reset_idx", 32'(digit_idx), 32'h0);

      // Scenario 1: full frame, all digits
      reset = 1'b0;
      for (int k = 0; k < 8; k++) run_slot(3'(k), AN_TBL[k], SEG_TBL[k], 1'b1);

      // Scenario 2: sparse enable, digits 2 and 7 alternate; dp on digit 7
      digit_en = 8'b1000_0100;
      dp_in    = 8'h80;
      run_slot(3'd2, 8'hFB, 7'h21, 1'b1);
      run_slot(3'd7, 8'h7F, 7'h00, 1'b0);
      run_slot(3'd2, 8'hFB, 7'h21, 1'b1);
      run_slot(3'd7, 8'h7F, 7'h00, 1'b0);

      // Scenario 3: value change mid-frame is not shown until the next frame
      digit_en = 8'hFF;
      dp_in    = 8'h00;
      for (int k = 0; k < 3; k++) run_slot(3'(k), AN_TBL[k], SEG_TBL[k], 1'b1);
      value = 32'h0000_0000;
      for (int k = 3; k < 8; k++) run_slot(3'(k), AN_TBL[k], SEG_TBL[k], 1'b1);
      run_slot(3'd0, 8'hFE, 7'h40, 1'b1);

      // Scenario 4: digit 1 disabled during its lit phase
      step();
      check("s4_idx", 32'(digit_idx), 32'h1);
      step();
      step();
      check("s4_lit_an", 32'(an), 32'hFD);
      digit_en = 8'hFD;
      for (int c = 0; c < 5; c++) begin
         step();
         check("s4_kill_idx", 32'(digit_idx), 32'h1);
         check("s4_kill_an", 32'(an), 32'hFF);
      end
      run_slot(3'd2, 8'hFB, 7'h40, 1'b1);

      // Scenario 5: all digits disabled mid-slot, then re-enable digit 4
      step();
      step();
      step();
      check("s5_lit_an", 32'(an), 32'hF7);
      digit_en = 8'h00;
      for (int c = 0; c < 5; c++) begin
         step();
         check("s5_tail_idx", 32'(digit_idx), 32'h3);
         check("s5_tail_an", 32'(an), 32'hFF);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         check_off("s5_idle");
         check("s5_idle_idx", 32'(digit_idx), 32'h0);
      end
      digit_en = 8'h10;
      run_slot(3'd4, 8'hEF, 7'h40, 1'b1);

      // Scenario 6: lone digit reselected, then async reset mid-drive
      value = 32'h89ABCDEF;
      step();
      check("s6_reselect_idx", 32'(digit_idx), 32'h4);
      step();
      step();
      check("s6_lit_an", 32'(an), 32'hEF);
      check("s6_lit_seg", 32'(seg), 32'h03);
      #3;
      reset = 1'b1;
      #1;
      check_off("s6_async");
      check("s6_async_idx", 32'(digit_idx), 32'h0);
      digit_en = 8'hFF;
      step();
      step();
      reset = 1'b0;
      run_slot(3'd0, 8'hFE, 7'h0E, 1'b1);
      run_slot(3'd1, 8'hFD, 7'h06, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
